// File: rtl/riscv_wb_oq_pkg.sv
// Shared types and opcode helpers for the in-order write-back completion queue.
package riscv_wb_oq_pkg;

    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcStoreFp = 7'b0100111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Ld  = 3'b011;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Lwu = 3'b110;

    typedef logic [4:0] rsd_t;

    typedef struct packed {
        logic        bubble;
        logic        dbg;
        logic [31:0] instr;
    } instruction_t;

    typedef struct packed {
        logic any;
        logic breakpoint;
        logic illegal_instruction;
        logic instruction_misaligned;
        logic instruction_access_fault;
        logic instruction_page_fault;
        logic load_misaligned;
        logic load_access_fault;
        logic load_page_fault;
        logic store_misaligned;
        logic store_access_fault;
        logic store_page_fault;
    } interrupts_exceptions_t;

    // Control part of a queue entry; XLEN-wide fields live in separate arrays.
    typedef struct packed {
        instruction_t           insn;
        interrupts_exceptions_t exc;
        logic [2:0]             adr_lsb;
        rsd_t                   rd;
        logic                   is_mem;
        logic                   done;
    } wbq_entry_t;

    function automatic logic [6:0] decode_opc(input logic [31:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [2:0] decode_funct3(input logic [31:0] instr);
        return instr[14:12];
    endfunction

    function automatic rsd_t decode_rd(input logic [31:0] instr);
        return instr[11:7];
    endfunction

    function automatic logic opc_writes_rd(input logic [6:0] opc);
        return !(opc inside {OpcStore, OpcStoreFp, OpcBranch, OpcMiscMem});
    endfunction

endpackage

// File: rtl/riscv_wb_oq_idxfifo.sv
// Index FIFO recording queue slots of outstanding memory ops in response order.
module riscv_wb_oq_idxfifo #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  logic [AW-1:0] idx_i,
    output logic [AW-1:0] idx_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (clear_i) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (push_i) begin
                r_wr <= r_wr + AW'(1);
            end
            if (pop_i) begin
                r_rd <= r_rd + AW'(1);
            end
            r_cnt <= r_cnt + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) begin
            r_mem[r_wr] <= idx_i;
        end
    end

    assign idx_o   = r_mem[r_rd];
    assign empty_o = (r_cnt == '0);
    assign full_o  = (r_cnt == CW'(DEPTH));

endmodule

// File: rtl/riscv_wb_oq.sv
// Write-back stage with an in-order completion queue: memory ops complete out of band,
// entries retire to the register file strictly in program order.
module riscv_wb_oq
    import riscv_wb_oq_pkg::*;
#(
    parameter int unsigned     XLEN    = 32,
    parameter logic [XLEN-1:0] PC_INIT = 'h200,
    parameter int unsigned     DEPTH   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   wb_stall_o,
    input  logic [XLEN-1:0]        mem_pc_i,
    input  instruction_t           mem_insn_i,
    input  interrupts_exceptions_t mem_exceptions_i,
    input  logic [XLEN-1:0]        mem_r_i,
    input  logic [XLEN-1:0]        mem_memadr_i,
    input  logic                   dmem_ack_i,
    input  logic                   dmem_err_i,
    input  logic                   dmem_misaligned_i,
    input  logic                   dmem_page_fault_i,
    input  logic [XLEN-1:0]        dmem_q_i,
    output logic [XLEN-1:0]        wb_memq_o,
    output logic [XLEN-1:0]        wb_pc_o,
    output instruction_t           wb_insn_o,
    output interrupts_exceptions_t wb_exceptions_o,
    output logic [XLEN-1:0]        wb_badaddr_o,
    output rsd_t                   wb_dst_o,
    output logic [XLEN-1:0]        wb_r_o,
    output logic                   wb_we_o
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned DW     = CW + 1;
    localparam int unsigned LANE_W = (XLEN == 64) ? 3 : 2;

    wbq_entry_t    r_ent [DEPTH];
    logic [XLEN-1:0] r_pc  [DEPTH];
    logic [XLEN-1:0] r_res [DEPTH];
    logic [XLEN-1:0] r_adr [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_drop_cnt;
    // Set by reset, cleared by the first push: beats in this window are stale leftovers.
    logic          r_orphan_ok;

    logic [XLEN-1:0]        r_wb_pc;
    instruction_t           r_wb_insn;
    interrupts_exceptions_t r_wb_exc;
    logic [XLEN-1:0]        r_wb_badaddr;
    rsd_t                   r_wb_dst;
    logic [XLEN-1:0]        r_wb_r;
    logic                   r_wb_we;

    logic                   w_beat;
    logic                   w_drop;
    logic                   w_hit;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic                   w_fifo_push;
    logic [AW-1:0]          w_rsp_idx;
    wbq_entry_t             w_tgt;
    wbq_entry_t             w_tgt_new;
    logic [XLEN-1:0]        w_tgt_res;
    logic                   w_tgt_load;
    logic                   w_tgt_store;
    interrupts_exceptions_t w_beat_exc;
    logic [LANE_W-1:0]      w_lane;
    logic [XLEN-1:0]        w_sh;
    logic [XLEN-1:0]        w_ext;
    logic                   w_head_byp;
    wbq_entry_t             w_head_ent;
    logic [XLEN-1:0]        w_head_res;
    logic                   w_retire;
    logic                   w_flush;
    logic                   w_push;
    logic                   w_push_mem;
    wbq_entry_t             w_push_ent;
    logic [AW-1:0]          w_scan_idx;
    logic [CW-1:0]          w_flush_cnt;
    logic [DW-1:0]          w_drop_sum;
    logic [CW-1:0]          w_drop_nxt;
    logic                   w_mem_fault;
    logic [XLEN-1:0]        w_badaddr;
    logic                   w_we;

    riscv_wb_oq_idxfifo #(
        .DEPTH (DEPTH)
    ) u_idxfifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_fifo_push),
        .pop_i   (w_hit),
        .clear_i (w_flush),
        .idx_i   (r_tail),
        .idx_o   (w_rsp_idx),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full)
    );

    assign w_beat = dmem_ack_i | dmem_err_i | dmem_misaligned_i | dmem_page_fault_i;
    assign w_drop = w_beat && (r_drop_cnt != '0);
    assign w_hit  = w_beat && (r_drop_cnt == '0) && !w_fifo_empty;

    assign w_tgt       = r_ent[w_rsp_idx];
    assign w_tgt_load  = decode_opc(w_tgt.insn.instr) == OpcLoad;
    assign w_tgt_store = decode_opc(w_tgt.insn.instr) == OpcStore;

    always_comb begin
        w_beat_exc = '0;
        if (w_tgt_store) begin
            w_beat_exc.store_access_fault = dmem_err_i;
            w_beat_exc.store_misaligned   = dmem_misaligned_i;
            w_beat_exc.store_page_fault   = dmem_page_fault_i;
        end else begin
            w_beat_exc.load_access_fault  = dmem_err_i;
            w_beat_exc.load_misaligned    = dmem_misaligned_i;
            w_beat_exc.load_page_fault    = dmem_page_fault_i;
        end
        w_beat_exc.any = dmem_err_i | dmem_misaligned_i | dmem_page_fault_i;
    end

    always_comb begin
        w_lane = w_tgt.adr_lsb[LANE_W-1:0];
        w_sh   = dmem_q_i >> {w_lane, 3'b000};
        case (decode_funct3(w_tgt.insn.instr))
            F3Lb:    w_ext = XLEN'($signed(w_sh[7:0]));
            F3Lh:    w_ext = XLEN'($signed(w_sh[15:0]));
            F3Lw:    w_ext = XLEN'($signed(w_sh[31:0]));
            F3Lbu:   w_ext = XLEN'(w_sh[7:0]);
            F3Lhu:   w_ext = XLEN'(w_sh[15:0]);
            F3Lwu:   w_ext = XLEN'(w_sh[31:0]);
            F3Ld:    w_ext = w_sh;
            default: w_ext = w_sh;
        endcase
        wb_memq_o = (w_tgt_load && !w_fifo_empty) ? w_ext : 'x;
    end

    always_comb begin
        w_tgt_new      = w_tgt;
        w_tgt_new.done = 1'b1;
        w_tgt_new.exc  = w_tgt.exc | w_beat_exc;
        w_tgt_res      = w_tgt_load ? w_ext : r_res[w_rsp_idx];
    end

    // A beat for the head entry lets it retire in the same cycle.
    assign w_head_byp = w_hit && (w_rsp_idx == r_head);
    assign w_head_ent = w_head_byp ? w_tgt_new : r_ent[r_head];
    assign w_head_res = w_head_byp ? w_tgt_res : r_res[r_head];
    assign w_retire   = (r_count != '0) && w_head_ent.done;
    assign w_flush    = w_retire && w_head_ent.exc.any;

    assign wb_stall_o = (r_count == CW'(DEPTH)) && !w_retire;
    assign w_push     = !wb_stall_o && !mem_insn_i.bubble && !r_wb_exc.any;
    assign w_push_mem = (decode_opc(mem_insn_i.instr) inside {OpcLoad, OpcStore})
                        && !mem_exceptions_i.any;
    assign w_fifo_push = w_push && w_push_mem && !w_flush;

    always_comb begin
        w_push_ent         = '0;
        w_push_ent.insn    = mem_insn_i;
        w_push_ent.exc     = mem_exceptions_i;
        w_push_ent.adr_lsb = mem_memadr_i[2:0];
        w_push_ent.rd      = decode_rd(mem_insn_i.instr);
        w_push_ent.is_mem  = w_push_mem;
        w_push_ent.done    = !w_push_mem;
    end

    // Younger mem entries still waiting will have their beats arrive later; count them.
    always_comb begin
        w_flush_cnt = '0;
        w_scan_idx  = '0;
        for (int k = 1; k < DEPTH; k++) begin
            w_scan_idx = r_head + AW'(k);
            if ((CW'(k) < r_count) && r_ent[w_scan_idx].is_mem && !r_ent[w_scan_idx].done
                && !(w_hit && (w_rsp_idx == w_scan_idx))) begin
                w_flush_cnt = w_flush_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        w_drop_sum = {1'b0, r_drop_cnt};
        if (w_drop) begin
            w_drop_sum = w_drop_sum - DW'(1);
        end
        if (w_flush) begin
            w_drop_sum = w_drop_sum + {1'b0, w_flush_cnt};
        end
        w_drop_nxt = (w_drop_sum > DW'(DEPTH)) ? CW'(DEPTH) : w_drop_sum[CW-1:0];
    end

    always_comb begin
        w_mem_fault = w_head_ent.exc.load_misaligned | w_head_ent.exc.load_access_fault
                    | w_head_ent.exc.load_page_fault | w_head_ent.exc.store_misaligned
                    | w_head_ent.exc.store_access_fault | w_head_ent.exc.store_page_fault
                    | w_head_ent.exc.breakpoint;
        if (w_mem_fault) begin
            w_badaddr = r_adr[r_head];
        end else if (w_head_ent.exc.illegal_instruction) begin
            w_badaddr = XLEN'(w_head_ent.insn.instr);
        end else begin
            w_badaddr = '0;
        end
        w_we = (|w_head_ent.rd) && !w_head_ent.exc.any
               && opc_writes_rd(decode_opc(w_head_ent.insn.instr));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_drop_cnt   <= '0;
            r_orphan_ok  <= 1'b1;
            r_wb_pc      <= PC_INIT;
            r_wb_insn    <= '{bubble: 1'b1, dbg: 1'b0, instr: '0};
            r_wb_exc     <= '0;
            r_wb_badaddr <= '0;
            r_wb_we      <= 1'b0;
        end else begin
            r_drop_cnt <= w_drop_nxt;
            if (w_push) begin
                r_orphan_ok <= 1'b0;
            end
            if (w_retire) begin
                r_wb_pc      <= r_pc[r_head];
                r_wb_insn    <= w_head_ent.insn;
                r_wb_exc     <= w_head_ent.exc;
                r_wb_badaddr <= w_badaddr;
                r_wb_we      <= w_we;
            end else begin
                r_wb_insn.bubble <= 1'b1;
                r_wb_exc         <= '0;
                r_wb_we          <= 1'b0;
            end
            if (w_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_retire) begin
                    r_head <= r_head + AW'(1);
                end
                if (w_push) begin
                    r_tail <= r_tail + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_retire);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_hit) begin
            r_ent[w_rsp_idx] <= w_tgt_new;
            r_res[w_rsp_idx] <= w_tgt_res;
        end
        if (w_push) begin
            r_ent[r_tail] <= w_push_ent;
            r_pc[r_tail]  <= mem_pc_i;
            r_res[r_tail] <= mem_r_i;
            r_adr[r_tail] <= mem_memadr_i;
        end
        if (w_retire) begin
            r_wb_dst <= w_head_ent.rd;
            r_wb_r   <= w_head_res;
        end
    end

    assign wb_pc_o         = r_wb_pc;
    assign wb_insn_o       = r_wb_insn;
    assign wb_exceptions_o = r_wb_exc;
    assign wb_badaddr_o    = r_wb_badaddr;
    assign wb_dst_o        = r_wb_dst;
    assign wb_r_o          = r_wb_r;
    assign wb_we_o         = r_wb_we;

    a_beat_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_beat |-> (w_hit || w_drop || r_orphan_ok));

    a_idxfifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_fifo_push && !w_hit) |-> !w_fifo_full);

endmodule

// File: tb/tb_riscv_wb_oq.sv
// Directed bench for riscv_wb_oq: ordering, back-pressure, flush/drop, extension, reset.
module tb_riscv_wb_oq;
    import riscv_wb_oq_pkg::*;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    // 32-bit instance
    logic                   wb_stall;
    logic [31:0]            mem_pc, mem_r, mem_adr, dmem_q;
    instruction_t           mem_insn;
    interrupts_exceptions_t mem_exc;
    logic                   dmem_ack, dmem_err, dmem_mis, dmem_pf;
    logic [31:0]            wb_memq, wb_pc, wb_badaddr, wb_r;
    instruction_t           wb_insn;
    interrupts_exceptions_t wb_exc;
    rsd_t                   wb_dst;
    logic                   wb_we;

    // 64-bit instance
    logic                   s64;
    logic [63:0]            m64_pc, m64_r, m64_adr, d64_q;
    instruction_t           m64_insn;
    interrupts_exceptions_t m64_exc;
    logic                   d64_ack, d64_zero;
    logic [63:0]            o64_memq, o64_pc, o64_badaddr, o64_r;
    instruction_t           o64_insn;
    interrupts_exceptions_t o64_exc;
    rsd_t                   o64_dst;
    logic                   o64_we;

    int checks   = 0;
    int failures = 0;

    riscv_wb_oq #(.XLEN(32), .PC_INIT(32'h200), .DEPTH(4)) u_dut (
        .clk_i (clk_i), .rst_ni (rst_ni), .wb_stall_o (wb_stall),
        .mem_pc_i (mem_pc), .mem_insn_i (mem_insn), .mem_exceptions_i (mem_exc),
        .mem_r_i (mem_r), .mem_memadr_i (mem_adr),
        .dmem_ack_i (dmem_ack), .dmem_err_i (dmem_err), .dmem_misaligned_i (dmem_mis),
        .dmem_page_fault_i (dmem_pf), .dmem_q_i (dmem_q),
        .wb_memq_o (wb_memq), .wb_pc_o (wb_pc), .wb_insn_o (wb_insn),
        .wb_exceptions_o (wb_exc), .wb_badaddr_o (wb_badaddr), .wb_dst_o (wb_dst),
        .wb_r_o (wb_r), .wb_we_o (wb_we)
    );

    riscv_wb_oq #(.XLEN(64), .PC_INIT(64'h200), .DEPTH(4)) u_dut64 (
        .clk_i (clk_i), .rst_ni (rst_ni), .wb_stall_o (s64),
        .mem_pc_i (m64_pc), .mem_insn_i (m64_insn), .mem_exceptions_i (m64_exc),
        .mem_r_i (m64_r), .mem_memadr_i (m64_adr),
        .dmem_ack_i (d64_ack), .dmem_err_i (d64_zero), .dmem_misaligned_i (d64_zero),
        .dmem_page_fault_i (d64_zero), .dmem_q_i (d64_q),
        .wb_memq_o (o64_memq), .wb_pc_o (o64_pc), .wb_insn_o (o64_insn),
        .wb_exceptions_o (o64_exc), .wb_badaddr_o (o64_badaddr), .wb_dst_o (o64_dst),
        .wb_r_o (o64_r), .wb_we_o (o64_we)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] ld(input logic [2:0] f3, input logic [4:0] rd);
        return {12'h000, 5'd1, f3, rd, OpcLoad};
    endfunction

    function automatic logic [31:0] add(input logic [4:0] rd);
        return {7'd0, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic issue(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] r, input logic [31:0] adr);
        mem_pc   = pc;
        mem_insn = '{bubble: 1'b0, dbg: 1'b0, instr: instr};
        mem_r    = r;
        mem_adr  = adr;
    endtask

    task automatic idle();
        mem_insn = '{bubble: 1'b1, dbg: 1'b0, instr: 32'h0};
    endtask

    task automatic beat(input logic ack, input logic err, input logic [31:0] q);
        dmem_ack = ack;
        dmem_err = err;
        dmem_q   = q;
    endtask

    initial begin
        idle();
        mem_pc = '0; mem_r = '0; mem_adr = '0; mem_exc = '0;
        beat(1'b0, 1'b0, 32'h0);
        dmem_mis = 1'b0; dmem_pf = 1'b0;
        m64_pc = '0; m64_r = '0; m64_adr = '0; m64_exc = '0; d64_q = '0;
        m64_insn = '{bubble: 1'b1, dbg: 1'b0, instr: 32'h0};
        d64_ack = 1'b0; d64_zero = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_pc", wb_pc, 32'h200);
        chk("rst_bubble", wb_insn.bubble, 1'b1);
        chk("rst_dbg", wb_insn.dbg, 1'b0);
        chk("rst_exc", wb_exc, '0);
        chk("rst_badaddr", wb_badaddr, 32'h0);
        chk("rst_we", wb_we, 1'b0);
        chk("rst_stall", wb_stall, 1'b0);
        rst_ni = 1'b1;
        tick();

        // 1: two loads, out-of-band acks, in-order retire with extension
        issue(32'h1000, ld(F3Lb, 5'd3), 32'h0, 32'h100); tick();
        issue(32'h1004, ld(F3Lbu, 5'd4), 32'h0, 32'h104); tick();
        idle(); tick();
        beat(1'b1, 1'b0, 32'h80); #1;
        chk("t1_memq", wb_memq, 32'hFFFF_FF80);
        chk("t1_stall", wb_stall, 1'b0);
        tick();
        chk("t1_a_we", wb_we, 1'b1);
        chk("t1_a_r", wb_r, 32'hFFFF_FF80);
        chk("t1_a_dst", wb_dst, 5'd3);
        chk("t1_a_pc", wb_pc, 32'h1000);
        beat(1'b0, 1'b0, 32'h0); tick();
        chk("t1_wait_we", wb_we, 1'b0);
        chk("t1_wait_bubble", wb_insn.bubble, 1'b1);
        beat(1'b1, 1'b0, 32'hFF); tick();
        chk("t1_b_r", wb_r, 32'h0000_00FF);
        chk("t1_b_dst", wb_dst, 5'd4);
        beat(1'b0, 1'b0, 32'h0); tick();

        // 2: fill the queue, stall on the 5th, release on first ack
        for (int k = 1; k <= 4; k++) begin
            issue(32'h1100 + 32'(4 * k), ld(F3Lw, 5'(5 + k)), 32'h0, 32'h200 + 32'(4 * k));
            tick();
        end
        issue(32'h1114, ld(F3Lw, 5'd10), 32'h0, 32'h214); #1;
        chk("t2_stall_full", wb_stall, 1'b1);
        tick();
        chk("t2_stall_held", wb_stall, 1'b1);
        beat(1'b1, 1'b0, 32'h11); #1;
        chk("t2_stall_drop", wb_stall, 1'b0);
        tick();
        idle();
        chk("t2_r1", wb_r, 32'h11);
        chk("t2_dst1", wb_dst, 5'd6);
        for (int k = 2; k <= 5; k++) begin
            beat(1'b1, 1'b0, 32'(k)); tick();
            chk("t2_dst", wb_dst, 5'(5 + k));
            chk("t2_r", wb_r, 32'(k));
        end
        beat(1'b0, 1'b0, 32'h0); tick();
        chk("t2_empty_we", wb_we, 1'b0);

        // 3: ALU op waits behind a load
        issue(32'h1200, ld(F3Lw, 5'd7), 32'h0, 32'h300); tick();
        issue(32'h1204, add(5'd5), 32'h7, 32'h0); tick();
        idle(); tick();
        chk("t3_add_waits", wb_we, 1'b0);
        beat(1'b1, 1'b0, 32'h1234); tick();
        chk("t3_ld_we", wb_we, 1'b1);
        chk("t3_ld_dst", wb_dst, 5'd7);
        beat(1'b0, 1'b0, 32'h0); tick();
        chk("t3_add_we", wb_we, 1'b1);
        chk("t3_add_dst", wb_dst, 5'd5);
        chk("t3_add_r", wb_r, 32'h7);
        tick();

        // 4: access fault flushes younger loads; their acks are dropped
        issue(32'h1300, ld(F3Lw, 5'd11), 32'h0, 32'h400); tick();
        issue(32'h1304, ld(F3Lw, 5'd12), 32'h0, 32'h404); tick();
        issue(32'h1308, ld(F3Lw, 5'd13), 32'h0, 32'h408); tick();
        idle(); beat(1'b0, 1'b1, 32'h0); tick();
        chk("t4_laf", wb_exc.load_access_fault, 1'b1);
        chk("t4_any", wb_exc.any, 1'b1);
        chk("t4_badaddr", wb_badaddr, 32'h400);
        chk("t4_we", wb_we, 1'b0);
        beat(1'b1, 1'b0, 32'hAA); tick();
        chk("t4_drop1_we", wb_we, 1'b0);
        tick();
        chk("t4_drop2_we", wb_we, 1'b0);
        beat(1'b0, 1'b0, 32'h0);
        issue(32'h1310, ld(F3Lw, 5'd14), 32'h0, 32'h40C); tick();
        idle(); beat(1'b1, 1'b0, 32'h55); tick();
        chk("t4_after_we", wb_we, 1'b1);
        chk("t4_after_r", wb_r, 32'h55);
        chk("t4_after_dst", wb_dst, 5'd14);
        beat(1'b0, 1'b0, 32'h0); tick();

        // 5: XLEN=64 LW from upper word with sign extension
        m64_pc = 64'h2000; m64_adr = 64'h1004;
        m64_insn = '{bubble: 1'b0, dbg: 1'b0, instr: ld(F3Lw, 5'd8)};
        tick();
        m64_insn = '{bubble: 1'b1, dbg: 1'b0, instr: 32'h0};
        d64_ack = 1'b1; d64_q = 64'h8000_0000_0000_0000; #1;
        chk("t5_memq", o64_memq, 64'hFFFF_FFFF_8000_0000);
        tick();
        chk("t5_r", o64_r, 64'hFFFF_FFFF_8000_0000);
        chk("t5_we", o64_we, 1'b1);
        d64_ack = 1'b0; tick();

        // 6: asynchronous reset with entries queued, stale ack afterwards
        issue(32'h3000, ld(F3Lw, 5'd15), 32'h0, 32'h500); tick();
        issue(32'h3004, ld(F3Lw, 5'd16), 32'h0, 32'h504); tick();
        issue(32'h3008, ld(F3Lw, 5'd17), 32'h0, 32'h508); tick();
        idle(); #2;
        rst_ni = 1'b0; #1;
        chk("t6_pc", wb_pc, 32'h200);
        chk("t6_bubble", wb_insn.bubble, 1'b1);
        chk("t6_we", wb_we, 1'b0);
        chk("t6_stall", wb_stall, 1'b0);
        chk("t6_exc", wb_exc, '0);
        tick();
        rst_ni = 1'b1;
        beat(1'b1, 1'b0, 32'h77); tick();
        chk("t6_late_we", wb_we, 1'b0);
        beat(1'b0, 1'b0, 32'h0);
        issue(32'h3100, add(5'd5), 32'h99, 32'h0); tick();
        idle(); tick();
        chk("t6_add_we", wb_we, 1'b1);
        chk("t6_add_r", wb_r, 32'h99);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
